button_debounce_pulse: RTL and testbench



---
 rtl/debounce_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debounce_pulse.sv | 114 +++++++++++
 tb/tb_button_debounce_pulse.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debounce path: FSM state encoding
// and the sizing helper for the debounce and hold/repeat counters.
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_e;

  // Counters only ever count up to (parameter - 1), so clog2 of the largest bound is enough.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debounce_pulse.sv
// Debounces a raw push-button and emits a one-cycle step pulse per accepted press,
// with optional hold-to-auto-repeat stepping while the button stays down.
module button_debounce_pulse
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 25000000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic repeat_en,
  output logic en_pulse,
  output logic btn_level
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             btn_s;
  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [CNT_W-1:0] hold_thr;
  logic             rep_phase_q;
  logic             en_pulse_q;
  logic             btn_level_q;

  sync_2ff u_sync_btn (
    .clk (clk),
    .rst (rst),
    .d_i (btn_in),
    .q_o (btn_s)
  );

  assign cnt_d      = cnt_q + CNT_ONE;
  assign hold_cnt_d = hold_cnt_q + CNT_ONE;
  // The first repeat waits the long hold time; later repeats use the shorter interval.
  assign hold_thr   = rep_phase_q ? REP_LAST : HOLD_LAST;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hold_cnt_q  <= '0;
      rep_phase_q <= 1'b0;
      en_pulse_q  <= 1'b0;
      btn_level_q <= 1'b0;
    end else begin
      en_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          btn_level_q <= 1'b0;
          if (btn_s) begin
            state_q <= ST_PRESS_WAIT;
            cnt_q   <= '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!btn_s) begin
            state_q <= ST_IDLE;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= ST_HELD;
            en_pulse_q  <= 1'b1;
            btn_level_q <= 1'b1;
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_HELD: begin
          // A release seen on the same cycle as a repeat threshold takes priority.
          if (!btn_s) begin
            state_q <= ST_RELEASE_WAIT;
            cnt_q   <= '0;
          end else if (repeat_en) begin
            if (hold_cnt_q == hold_thr) begin
              en_pulse_q  <= 1'b1;
              hold_cnt_q  <= '0;
              rep_phase_q <= 1'b1;
            end else begin
              hold_cnt_q <= hold_cnt_d;
            end
          end else begin
            hold_cnt_q  <= '0;
            rep_phase_q <= 1'b0;
          end
        end
        ST_RELEASE_WAIT: begin
          if (btn_s) begin
            state_q <= ST_HELD;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= ST_IDLE;
            btn_level_q <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign en_pulse  = en_pulse_q;
  assign btn_level = btn_level_q;

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Self-checking bench for button_debounce_pulse: directed latency scenarios plus a
// randomized bouncing-button stream compared against a run-length reference model.
module tb_button_debounce_pulse;

  localparam int DEB  = 4;
  localparam int HOLD = 6;
  localparam int REP  = 3;

  logic clk;
  logic rst;
  logic btn_in;
  logic repeat_en;
  logic en_pulse;
  logic btn_level;

  int total = 0;
  int bad   = 0;
  int edgeNo = 0;
  int levelRise = -1;
  int levelFall = -1;
  int pulseEdges[$];
  int counterValue = 0;
  logic prevPulse = 1'b0;
  logic prevLevel = 1'b0;

  // Reference model: synchroniser delay line, then the debounced level flips once btn_s
  // has disagreed with it for DEB+1 consecutive samples; hold time accrues only on
  // samples where the button is settled down with no pending release run.
  logic mS1 = 1'b0;
  logic mS2 = 1'b0;
  logic mLevel = 1'b0;
  logic mPhase = 1'b0;
  logic expPulse = 1'b0;
  int   mRun = 0;
  int   mHeld = 0;

  int   rLen;
  logic rBtn = 1'b0;
  logic rRep = 1'b0;

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES (DEB),
    .HOLD_CYCLES     (HOLD),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .repeat_en (repeat_en),
    .en_pulse  (en_pulse),
    .btn_level (btn_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d (edge %0d)", tag, got, exp, edgeNo);
    end
  endtask

  task automatic modelStep(input logic r, input logic b, input logic rp);
    logic s;
    expPulse = 1'b0;
    if (r) begin
      mS1 = 1'b0; mS2 = 1'b0; mLevel = 1'b0; mPhase = 1'b0;
      mRun = 0; mHeld = 0;
    end else begin
      s = mS2;
      if (s != mLevel) begin
        mRun++;
        if (mRun == DEB + 1) begin
          mLevel = s;
          mRun = 0;
          if (s) begin
            expPulse = 1'b1;
            mHeld = 0;
            mPhase = 1'b0;
          end
        end
      end else begin
        if (mLevel && mRun == 0) begin
          if (rp) begin
            mHeld++;
            if (mHeld == (mPhase ? REP : HOLD)) begin
              expPulse = 1'b1;
              mHeld = 0;
              mPhase = 1'b1;
            end
          end else begin
            mHeld = 0;
            mPhase = 1'b0;
          end
        end
        mRun = 0;
      end
      mS2 = mS1;
      mS1 = b;
    end
  endtask

  task automatic applyStimulus(input logic r, input logic b, input logic rp);
    rst = r; btn_in = b; repeat_en = rp;
    @(posedge clk);
    #1;
    edgeNo++;
    modelStep(r, b, rp);
    checkOutput("en_pulse", 32'(en_pulse), 32'(expPulse));
    checkOutput("btn_level", 32'(btn_level), 32'(mLevel));
    checkOutput("pulse_gap", 32'(en_pulse & prevPulse), 32'd0);
    if (en_pulse) begin
      pulseEdges.push_back(edgeNo);
      counterValue++;
    end
    if (btn_level && !prevLevel && levelRise < 0) levelRise = edgeNo;
    if (!btn_level && prevLevel && levelFall < 0) levelFall = edgeNo;
    prevPulse = en_pulse;
    prevLevel = btn_level;
  endtask

  task automatic runFor(input int n, input logic b, input logic rp);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, b, rp);
  endtask

  task automatic startScenario();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    edgeNo = 0;
    pulseEdges.delete();
    levelRise = -1;
    levelFall = -1;
  endtask

  task automatic checkPulses(input string tag, input int n, input int e0, input int e1,
                             input int e2, input int e3);
    int exp[4];
    int got;
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    checkOutput({tag, "_count"}, pulseEdges.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < pulseEdges.size()) ? pulseEdges[i] : -1;
      checkOutput({tag, "_edge"}, got, exp[i]);
    end
  endtask

  initial begin
    rst = 1'b1; btn_in = 1'b0; repeat_en = 1'b0;

    // Reset state
    startScenario();
    checkOutput("reset_en_pulse", 32'(en_pulse), 32'd0);
    checkOutput("reset_btn_level", 32'(btn_level), 32'd0);

    // Clean press: rise after edge 10, pulse and level at edge 17
    startScenario();
    runFor(10, 1'b0, 1'b0);
    runFor(12, 1'b1, 1'b0);
    checkPulses("t1_press", 1, 17, 0, 0, 0);
    checkOutput("t1_level_rise", levelRise, 17);

    // Bounce: high 3, low 1, then steady; single pulse 7 edges after final rise
    startScenario();
    runFor(10, 1'b0, 1'b0);
    runFor(3, 1'b1, 1'b0);
    runFor(1, 1'b0, 1'b0);
    runFor(12, 1'b1, 1'b0);
    checkPulses("t2_bounce", 1, 21, 0, 0, 0);

    // Release with a 2-cycle glitch during the hold; level falls 7 edges after final fall
    startScenario();
    runFor(10, 1'b0, 1'b0);
    runFor(15, 1'b1, 1'b0);
    runFor(2, 1'b0, 1'b0);
    runFor(10, 1'b1, 1'b0);
    runFor(15, 1'b0, 1'b0);
    checkPulses("t3_release", 1, 17, 0, 0, 0);
    checkOutput("t3_level_fall", levelFall, 44);

    // Auto-repeat enabled: 17, 23, 26, 29
    startScenario();
    runFor(10, 1'b0, 1'b1);
    runFor(20, 1'b1, 1'b1);
    checkPulses("t4_repeat", 4, 17, 23, 26, 29);

    // Auto-repeat disabled: single pulse
    startScenario();
    runFor(10, 1'b0, 1'b0);
    runFor(20, 1'b1, 1'b0);
    checkPulses("t4_norepeat", 1, 17, 0, 0, 0);

    // Reset mid-hold at edge 21, button still down; next pulse at 28
    startScenario();
    runFor(10, 1'b0, 1'b0);
    runFor(10, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("t5_level_after_rst", 32'(btn_level), 32'd0);
    checkOutput("t5_pulse_after_rst", 32'(en_pulse), 32'd0);
    runFor(10, 1'b1, 1'b0);
    checkPulses("t5_reset", 2, 17, 28, 0, 0);

    // Ten press/release cycles advance the downstream counter by ten
    startScenario();
    counterValue = 0;
    for (int i = 0; i < 10; i++) begin
      runFor(8, 1'b1, 1'b0);
      runFor(8, 1'b0, 1'b0);
    end
    checkOutput("t6_counter", counterValue, 10);

    // Randomized bouncing stream with repeat toggling and occasional reset
    startScenario();
    for (int seg = 0; seg < 250; seg++) begin
      rLen = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 9));
      rBtn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) rRep = ~rRep;
      if ($urandom_range(0, 60) == 0) applyStimulus(1'b1, rBtn, rRep);
      runFor(rLen, rBtn, rRep);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
